// File: rtl/blackjack_deal_sequencer.sv
// rtl/blackjack_deal_sequencer.sv - round controller for one player vs dealer
// Pulls cards from the shuffle/deal datapath, applies the dealer stand rule and reports the result.
module blackjack_deal_sequencer #(
    parameter int DECK_SIZE    = 52,
    parameter int RESHUFFLE_AT = 15,
    parameter int DEALER_STAND = 17
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_hit,
    input  logic       i_stand,
    output logic       o_shuffle_req,
    input  logic       i_shuffle_done,
    output logic       o_card_req,
    input  logic       i_card_valid,
    input  logic [5:0] i_card_in,
    output logic [4:0] o_player_total,
    output logic [4:0] o_dealer_total,
    output logic [5:0] o_cards_left,
    output logic       o_await_player,
    output logic       o_busy,
    output logic [1:0] o_result,
    output logic       o_result_valid
);

    typedef enum logic [3:0] {
        IDLE, SHUFFLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
        PLAYER, PLAYER_HIT, DEALER, DEALER_HIT, RESOLVE, DONE
    } state_t;

    state_t     r_state, w_next, r_ret_state;
    logic [5:0] r_cards_left;
    logic [4:0] r_p_hard, r_d_hard;
    logic       r_p_ace, r_d_ace, r_natural;
    logic [1:0] r_result;

    logic       w_card_state, w_player_card, w_card_ok, w_start_ok, w_need_shuffle;
    logic [5:0] w_rank;
    logic [4:0] w_value;
    logic       w_is_ace;
    logic [4:0] w_p_total, w_d_total, w_p_total_new;
    logic [1:0] w_result;

    function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    assign w_card_state   = (r_state == DEAL_P1) || (r_state == DEAL_D1) || (r_state == DEAL_P2) ||
                            (r_state == DEAL_D2) || (r_state == PLAYER_HIT) || (r_state == DEALER_HIT);
    assign w_player_card  = (r_state == DEAL_P1) || (r_state == DEAL_P2) || (r_state == PLAYER_HIT);
    assign w_need_shuffle = w_card_state && (r_cards_left == 6'd0);
    // Out-of-range indices are treated as no card at all: request stays up.
    assign w_card_ok      = w_card_state && !w_need_shuffle && i_card_valid && (i_card_in <= 6'd51);
    assign w_start_ok     = i_start && ((r_state == IDLE) || (r_state == DONE));

    assign w_rank   = i_card_in % 6'd13;
    assign w_is_ace = (w_rank == 6'd0);
    always_comb begin
        w_value = 5'd10;
        if (w_is_ace)
            w_value = 5'd1;
        else if (w_rank <= 6'd8)
            w_value = 5'(w_rank + 6'd1);
    end

    assign w_p_total     = best_total(r_p_hard, r_p_ace);
    assign w_d_total     = best_total(r_d_hard, r_d_ace);
    assign w_p_total_new = best_total(r_p_hard + w_value, r_p_ace | w_is_ace);

    always_comb begin
        w_result = 2'b11;
        if (w_p_total > 5'd21)
            w_result = 2'b10;
        else if (r_natural)
            w_result = (w_d_total == 5'd21) ? 2'b11 : 2'b01;
        else if (w_d_total > 5'd21)
            w_result = 2'b01;
        else if (w_p_total > w_d_total)
            w_result = 2'b01;
        else if (w_p_total < w_d_total)
            w_result = 2'b10;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (i_start)
                    w_next = (r_cards_left < 6'(RESHUFFLE_AT)) ? SHUFFLE : DEAL_P1;
            end
            SHUFFLE: begin
                if (i_shuffle_done)
                    w_next = r_ret_state;
            end
            DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_HIT, DEALER_HIT: begin
                if (w_need_shuffle)
                    w_next = SHUFFLE;
                else if (w_card_ok) begin
                    case (r_state)
                        DEAL_P1:    w_next = DEAL_D1;
                        DEAL_D1:    w_next = DEAL_P2;
                        DEAL_P2:    w_next = DEAL_D2;
                        DEAL_D2:    w_next = (w_p_total == 5'd21) ? RESOLVE : PLAYER;
                        PLAYER_HIT: w_next = (w_p_total_new > 5'd21)  ? RESOLVE :
                                             (w_p_total_new == 5'd21) ? DEALER  : PLAYER;
                        default:    w_next = DEALER;
                    endcase
                end
            end
            PLAYER: begin
                if (i_stand)
                    w_next = DEALER;
                else if (i_hit)
                    w_next = PLAYER_HIT;
            end
            DEALER:  w_next = (w_d_total < 5'(DEALER_STAND)) ? DEALER_HIT : RESOLVE;
            RESOLVE: w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_shuffle_req  = (r_state == SHUFFLE);
        o_card_req     = w_card_state && !w_need_shuffle;
        o_await_player = (r_state == PLAYER);
        o_busy         = (r_state != IDLE) && (r_state != DONE);
        o_result_valid = (r_state == DONE);
        o_player_total = w_p_total;
        o_dealer_total = w_d_total;
        o_cards_left   = r_cards_left;
        o_result       = r_result;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ret_state  <= IDLE;
            r_cards_left <= 6'd0;
            r_p_hard     <= 5'd0;
            r_d_hard     <= 5'd0;
            r_p_ace      <= 1'b0;
            r_d_ace      <= 1'b0;
            r_natural    <= 1'b0;
            r_result     <= 2'b00;
        end else begin
            if (w_start_ok) begin
                r_ret_state <= DEAL_P1;
                r_p_hard    <= 5'd0;
                r_d_hard    <= 5'd0;
                r_p_ace     <= 1'b0;
                r_d_ace     <= 1'b0;
                r_natural   <= 1'b0;
                r_result    <= 2'b00;
            end
            // An empty deck mid-round resumes the interrupted deal state after shuffling.
            if (w_need_shuffle)
                r_ret_state <= r_state;
            if ((r_state == SHUFFLE) && i_shuffle_done)
                r_cards_left <= 6'(DECK_SIZE);
            if (w_card_ok) begin
                r_cards_left <= r_cards_left - 6'd1;
                if (w_player_card) begin
                    r_p_hard <= r_p_hard + w_value;
                    r_p_ace  <= r_p_ace | w_is_ace;
                end else begin
                    r_d_hard <= r_d_hard + w_value;
                    r_d_ace  <= r_d_ace | w_is_ace;
                end
                if (r_state == DEAL_D2)
                    r_natural <= (w_p_total == 5'd21);
            end
            if (r_state == RESOLVE)
                r_result <= w_result;
        end
    end

endmodule

// File: tb/tb_blackjack_deal_sequencer.sv
// tb/tb_blackjack_deal_sequencer.sv - scoreboard bench for blackjack_deal_sequencer
module tb_blackjack_deal_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0, i_hit = 1'b0, i_stand = 1'b0;
    logic       i_shuffle_done = 1'b0, i_card_valid = 1'b0;
    logic [5:0] i_card_in = 6'd0;
    logic       o_shuffle_req, o_card_req, o_await_player, o_busy, o_result_valid;
    logic [4:0] o_player_total, o_dealer_total;
    logic [5:0] o_cards_left;
    logic [1:0] o_result;

    typedef struct {
        logic [1:0] res;
        logic [4:0] pt;
        logic [4:0] dt;
        logic [5:0] cl;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_rv = 1'b0;

    always #5 clk = ~clk;

    blackjack_deal_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_hit(i_hit), .i_stand(i_stand),
        .o_shuffle_req(o_shuffle_req), .i_shuffle_done(i_shuffle_done),
        .o_card_req(o_card_req), .i_card_valid(i_card_valid), .i_card_in(i_card_in),
        .o_player_total(o_player_total), .o_dealer_total(o_dealer_total),
        .o_cards_left(o_cards_left), .o_await_player(o_await_player), .o_busy(o_busy),
        .o_result(o_result), .o_result_valid(o_result_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly presented result against the scoreboard.
    always @(negedge clk) begin
        if (o_result_valid && !prev_rv) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d expected none", o_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 32'(o_result), 32'(e.res));
                check("player_total", 32'(o_player_total), 32'(e.pt));
                check("dealer_total", 32'(o_dealer_total), 32'(e.dt));
                check("cards_left", 32'(o_cards_left), 32'(e.cl));
            end
        end
        prev_rv = o_result_valid;
    end

    function automatic logic sig_val(input int sel);
        case (sel)
            0:       return o_card_req;
            1:       return o_shuffle_req;
            2:       return o_await_player;
            default: return o_result_valid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string what);
        int n = 0;
        while (!sig_val(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sig_val(sel)) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%s: got 0 expected 1", what);
        end
    endtask

    task automatic push_exp(input logic [1:0] res, input logic [4:0] pt, input logic [4:0] dt,
                            input logic [5:0] cl);
        exp_t e;
        e.res = res; e.pt = pt; e.dt = dt; e.cl = cl;
        sb_q.push_back(e);
    endtask

    task automatic give_card(input logic [5:0] idx);
        wait_sig(0, "card_req");
        i_card_valid = 1'b1;
        i_card_in    = idx;
        @(negedge clk);
        i_card_valid = 1'b0;
    endtask

    task automatic do_shuffle();
        wait_sig(1, "shuffle_req");
        i_shuffle_done = 1'b1;
        @(negedge clk);
        i_shuffle_done = 1'b0;
        check("shuffle_req_drop", 32'(o_shuffle_req), 32'd0);
        check("cards_left_loaded", 32'(o_cards_left), 32'd52);
    endtask

    task automatic pulse(input int which);
        if (which == 0) i_start = 1'b1;
        if (which == 1) i_hit = 1'b1;
        if (which == 2) i_stand = 1'b1;
        if (which == 3) begin i_hit = 1'b1; i_stand = 1'b1; end
        @(negedge clk);
        i_start = 1'b0; i_hit = 1'b0; i_stand = 1'b0;
    endtask

    task automatic deal4(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                         input logic [5:0] d);
        give_card(a); give_card(b); give_card(c); give_card(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({o_shuffle_req, o_card_req, o_player_total, o_dealer_total,
              o_cards_left, o_await_player, o_busy, o_result, o_result_valid}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round 1: first start must shuffle; natural 21 beats dealer 16.
        pulse(0);
        check("first_start_shuffles", 32'(o_shuffle_req), 32'd1);
        do_shuffle();
        push_exp(2'b01, 5'd21, 5'd16, 6'd48);
        deal4(6'd9, 6'd5, 6'd0, 6'd12);
        wait_sig(3, "result_r1");
        @(negedge clk);

        // Round 2: player 20 hits a 5 and busts; dealer draws nothing.
        pulse(0);
        check("no_shuffle_r2", 32'({o_shuffle_req, o_card_req}), 32'b01);
        push_exp(2'b10, 5'd25, 5'd5, 6'd43);
        deal4(6'd9, 6'd1, 6'd22, 6'd2);
        wait_sig(2, "await_r2");
        pulse(1);
        give_card(6'd4);
        wait_sig(3, "result_r2");
        seen = 1'b0;
        repeat (5) begin
            seen = seen | o_card_req;
            @(negedge clk);
        end
        check("card_req_idle_after_bust", 32'(seen), 32'd0);

        // Round 3: dealer soft 17 stands against player 5.
        pulse(0);
        push_exp(2'b10, 5'd5, 5'd17, 6'd39);
        deal4(6'd1, 6'd0, 6'd2, 6'd5);
        wait_sig(2, "await_r3");
        pulse(2);
        wait_sig(3, "result_r3");
        @(negedge clk);

        // Round 4: illegal card ignored; hit+stand stands; dealer draws to 18 for a push.
        pulse(0);
        wait_sig(0, "card_req_r4");
        i_card_valid = 1'b1;
        i_card_in    = 6'd60;
        @(negedge clk);
        i_card_valid = 1'b0;
        check("illegal_card_req_held", 32'(o_card_req), 32'd1);
        check("illegal_card_no_count", 32'(o_cards_left), 32'd39);
        push_exp(2'b11, 5'd18, 5'd18, 6'd33);
        deal4(6'd9, 6'd3, 6'd7, 6'd11);
        wait_sig(2, "await_r4");
        pulse(3);
        check("hit_stand_to_dealer", 32'({o_await_player, o_card_req, o_player_total}), 32'd18);
        give_card(6'd1);
        give_card(6'd1);
        wait_sig(3, "result_r4");
        @(negedge clk);

        // Round 5: long round, player stands on 20, dealer busts at 26, deck drops to 14.
        pulse(0);
        push_exp(2'b01, 5'd20, 5'd26, 6'd14);
        deal4(6'd1, 6'd1, 6'd1, 6'd1);
        for (int i = 0; i < 8; i++) begin
            wait_sig(2, "await_r5");
            pulse(1);
            give_card(6'd1);
        end
        wait_sig(2, "await_r5_stand");
        pulse(2);
        for (int i = 0; i < 6; i++) give_card(6'd1);
        give_card(6'd12);
        wait_sig(3, "result_r5");
        @(negedge clk);

        // Round 6: low deck reshuffles; reset in DEALER_HIT clears everything at once.
        pulse(0);
        check("low_deck_shuffles", 32'(o_shuffle_req), 32'd1);
        do_shuffle();
        deal4(6'd9, 6'd1, 6'd7, 6'd2);
        wait_sig(2, "await_r6");
        pulse(2);
        wait_sig(0, "dealer_hit_req");
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({o_shuffle_req, o_card_req, o_player_total, o_dealer_total,
              o_cards_left, o_await_player, o_busy, o_result, o_result_valid}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse(0);
        check("post_reset_shuffles", 32'(o_shuffle_req), 32'd1);
        do_shuffle();

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
